matmul_ctrl: RTL and testbench

MATMUL_CTRL -- requirements
Module: matmul_ctrl

---
 rtl/matmul_ctrl_pkg.sv | 25 ++
 rtl/matmul_ctrl_if.sv | 34 +++
 rtl/matmul_ctrl_tag_delay.sv | 32 +++
 rtl/matmul_ctrl.sv | 165 ++++++++++++++++
 tb/tb_matmul_ctrl.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/matmul_ctrl_pkg.sv
// Shared types for the matrix-multiply controller: FSM state encoding and the
// per-issue tag record carried alongside the datapath.
package matmul_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Tag index is fixed-width so the record layout is project-wide; AW must not exceed it.
  localparam int unsigned TAG_IDX_W = 16;

  typedef struct packed {
    logic                 valid;
    logic                 first;
    logic                 last;
    logic [TAG_IDX_W-1:0] idx;
  } tag_t;

  localparam int unsigned TAG_W = $bits(tag_t);

endpackage

// File: rtl/matmul_ctrl_if.sv
// Control bus between the matmul controller and its host / RAM / accumulator datapath.
interface matmul_ctrl_if #(
  parameter int unsigned AW = 4
);

  logic          start;
  logic          ld_valid;
  logic          ld_ready;
  logic          we_m1;
  logic          we_m2;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] rd_addr_m1;
  logic [AW-1:0] rd_addr_m2;
  logic          acc_ena;
  logic          acc_clr;
  logic          res_valid;
  logic [AW-1:0] res_idx;
  logic          busy;
  logic          done;

  // master: the controller; slave: host, RAMs and accumulators it sequences
  modport master (
    input  start, ld_valid,
    output ld_ready, we_m1, we_m2, wr_addr, rd_addr_m1, rd_addr_m2,
           acc_ena, acc_clr, res_valid, res_idx, busy, done
  );

  modport slave (
    output start, ld_valid,
    input  ld_ready, we_m1, we_m2, wr_addr, rd_addr_m1, rd_addr_m2,
           acc_ena, acc_clr, res_valid, res_idx, busy, done
  );

endinterface

// File: rtl/matmul_ctrl_tag_delay.sv
// Fixed-depth shift register that delays issue tags to line up with the
// product-sum arriving at the accumulators.
module tag_delay #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned W     = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout
);

  generate
    if (DEPTH == 0) begin : g_pass
      assign dout = din;
    end else begin : g_sr
      logic [W-1:0] sr [DEPTH];

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int s = 0; s < int'(DEPTH); s++) sr[s] <= '0;
        end else begin
          sr[0] <= din;
          for (int s = 1; s < int'(DEPTH); s++) sr[s] <= sr[s-1];
        end
      end

      assign dout = sr[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/matmul_ctrl.sv
// Sequencer for a DIM x DIM complex matrix multiply: loads both operand RAMs,
// issues i/j/k reads, and steers the accumulators via a delayed tag stream.
module matmul_ctrl
  import matmul_ctrl_pkg::*;
#(
  parameter int unsigned DIM      = 3,
  parameter int unsigned PIPE_LAT = 3,
  parameter int unsigned AW       = $clog2(DIM*DIM-1)+1
) (
  input  logic          clk,
  input  logic          rst,
  matmul_ctrl_if.master bus
);

  localparam int unsigned CW  = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int unsigned NEL = DIM * DIM;

  state_t                 state, state_n;
  logic [AW-1:0]          waddr;
  logic                   msel;
  logic [CW-1:0]          ci, cj, ck;
  logic [CW-1:0]          ci_n, cj_n, ck_n;
  logic [AW-1:0]          rd_m1, rd_m2;
  logic                   fire_c, last_beat_c, last_issue_c;
  tag_t                   tag_in, tag_out;
  logic                   res_v;
  logic [TAG_IDX_W-1:0]   res_i;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_n;
  end

  // Next-state and handshake decode
  always_comb begin
    state_n      = state;
    fire_c       = 1'b0;
    last_beat_c  = 1'b0;
    last_issue_c = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.start) state_n = ST_LOAD;
      end
      ST_LOAD: begin
        fire_c      = bus.ld_valid;
        last_beat_c = fire_c & msel & (waddr == AW'(NEL-1));
        if (last_beat_c) state_n = ST_RUN;
      end
      ST_RUN: begin
        last_issue_c = (ci == CW'(DIM-1)) && (cj == CW'(DIM-1)) && (ck == CW'(DIM-1));
        if (last_issue_c) state_n = ST_DRAIN;
      end
      ST_DRAIN: begin
        // The final element's result is the last event out of the tag pipe.
        if (res_v && (res_i == TAG_IDX_W'(NEL-1))) state_n = ST_DONE;
      end
      ST_DONE: begin
        state_n = ST_IDLE;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // k innermost, then j, then i
  always_comb begin
    ck_n = ck + CW'(1);
    cj_n = cj;
    ci_n = ci;
    if (ck == CW'(DIM-1)) begin
      ck_n = '0;
      cj_n = cj + CW'(1);
      if (cj == CW'(DIM-1)) begin
        cj_n = '0;
        ci_n = ci + CW'(1);
      end
    end
  end

  // Load beat counter: waddr walks each matrix, msel picks matrix 2
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      waddr <= '0;
      msel  <= 1'b0;
    end else if (fire_c) begin
      if (waddr == AW'(NEL-1)) begin
        waddr <= '0;
        msel  <= ~msel;
      end else begin
        waddr <= waddr + AW'(1);
      end
    end
  end

  // Issue counters and registered read addresses; addresses hold outside RUN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ci    <= '0;
      cj    <= '0;
      ck    <= '0;
      rd_m1 <= '0;
      rd_m2 <= '0;
    end else if (last_beat_c) begin
      ci    <= '0;
      cj    <= '0;
      ck    <= '0;
      rd_m1 <= '0;
      rd_m2 <= '0;
    end else if ((state == ST_RUN) && !last_issue_c) begin
      ci    <= ci_n;
      cj    <= cj_n;
      ck    <= ck_n;
      rd_m1 <= AW'(32'(ci_n) * DIM + 32'(ck_n));
      rd_m2 <= AW'(32'(ck_n) * DIM + 32'(cj_n));
    end
  end

  // Tag for the read issued this cycle
  always_comb begin
    tag_in = '0;
    if (state == ST_RUN) begin
      tag_in.valid = 1'b1;
      tag_in.first = (ck == '0);
      tag_in.last  = (ck == CW'(DIM-1));
      tag_in.idx   = TAG_IDX_W'(32'(ci) * DIM + 32'(cj));
    end
  end

  tag_delay #(
    .DEPTH (PIPE_LAT),
    .W     (TAG_W)
  ) u_tag_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (tag_in),
    .dout (tag_out)
  );

  // Result strobe lands the cycle after the last accumulate of an element
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      res_v <= 1'b0;
      res_i <= '0;
    end else begin
      res_v <= tag_out.valid & tag_out.last;
      if (tag_out.valid & tag_out.last) res_i <= tag_out.idx;
    end
  end

  assign bus.ld_ready   = (state == ST_LOAD);
  assign bus.we_m1      = fire_c & ~msel;
  assign bus.we_m2      = fire_c & msel;
  assign bus.wr_addr    = waddr;
  assign bus.rd_addr_m1 = rd_m1;
  assign bus.rd_addr_m2 = rd_m2;
  assign bus.acc_ena    = tag_out.valid;
  assign bus.acc_clr    = tag_out.valid & tag_out.first;
  assign bus.res_valid  = res_v;
  assign bus.res_idx    = AW'(res_i);
  assign bus.busy       = (state != ST_IDLE);
  assign bus.done       = (state == ST_DONE);

endmodule

// File: tb/tb_matmul_ctrl.sv
// Directed bench for matmul_ctrl with a behavioural RAM / complex-MAC datapath
// driven by the controller's strobes.
module tb_matmul_ctrl;
  import matmul_ctrl_pkg::*;

  localparam int unsigned DIM      = 3;
  localparam int unsigned PIPE_LAT = 3;
  localparam int unsigned AW       = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  matmul_ctrl_if #(.AW(AW)) bus ();

  matmul_ctrl #(.DIM(DIM), .PIPE_LAT(PIPE_LAT), .AW(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Datapath: sync-read RAMs, product stage, sum stage, accumulators
  logic signed [15:0] ld_re, ld_im;
  logic signed [15:0] m1_re [16];
  logic signed [15:0] m1_im [16];
  logic signed [15:0] m2_re [16];
  logic signed [15:0] m2_im [16];
  logic signed [15:0] a_re, a_im, b_re, b_im;
  logic signed [31:0] p_rr, p_ii, p_ri, p_ir, s_re, s_im, acc_re, acc_im;

  always @(posedge clk) begin
    if (bus.we_m1) begin
      m1_re[bus.wr_addr] <= ld_re;
      m1_im[bus.wr_addr] <= ld_im;
    end
    if (bus.we_m2) begin
      m2_re[bus.wr_addr] <= ld_re;
      m2_im[bus.wr_addr] <= ld_im;
    end
    a_re <= m1_re[bus.rd_addr_m1];
    a_im <= m1_im[bus.rd_addr_m1];
    b_re <= m2_re[bus.rd_addr_m2];
    b_im <= m2_im[bus.rd_addr_m2];
    p_rr <= 32'(a_re) * 32'(b_re);
    p_ii <= 32'(a_im) * 32'(b_im);
    p_ri <= 32'(a_re) * 32'(b_im);
    p_ir <= 32'(a_im) * 32'(b_re);
    s_re <= p_rr - p_ii;
    s_im <= p_ri + p_ir;
    if (bus.acc_ena) begin
      acc_re <= bus.acc_clr ? s_re : acc_re + s_re;
      acc_im <= bus.acc_clr ? s_im : acc_im + s_im;
    end
  end

  // Result / done logger
  int res_cnt;
  int done_cnt;
  int res_idx_log [64];
  int res_re_log  [64];
  int res_im_log  [64];

  initial begin
    res_cnt  = 0;
    done_cnt = 0;
  end

  always @(negedge clk) begin
    if (bus.res_valid === 1'b1 && res_cnt < 64) begin
      res_idx_log[res_cnt] <= int'(bus.res_idx);
      res_re_log[res_cnt]  <= acc_re;
      res_im_log[res_cnt]  <= acc_im;
      res_cnt              <= res_cnt + 1;
    end
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
    end
  endtask

  function automatic logic [31:0] outs();
    return 32'({bus.ld_ready, bus.we_m1, bus.we_m2, bus.wr_addr, bus.rd_addr_m1,
                bus.rd_addr_m2, bus.acc_ena, bus.acc_clr, bus.res_valid,
                bus.res_idx, bus.busy, bus.done});
  endfunction

  // Matrix 2 contents, element e = i*3+j; matrix 1 is the identity
  function automatic int m2r(int e, int off);
    return e - 3 + off;
  endfunction

  function automatic int m2i(int e, int off);
    return 2 * e + 1 - off;
  endfunction

  // Entered just after a negedge in LOAD; returns #1 after the negedge following beat 17
  task automatic do_load(input int gap_at, input int gap_len, input int off);
    for (int b = 0; b < 18; b++) begin
      if (b == gap_at) begin
        for (int g = 0; g < gap_len; g++) begin
          bus.ld_valid = 1'b0;
          ld_re        = 16'sd77;
          ld_im        = -16'sd77;
          #1;
          chk("gap_we", 32'({bus.we_m1, bus.we_m2}), 32'd0);
          @(negedge clk);
        end
      end
      if (b < 9) begin
        ld_re = 16'((b % 4 == 0) ? 1 : 0);
        ld_im = 16'sd0;
      end else begin
        ld_re = 16'(m2r(b - 9, off));
        ld_im = 16'(m2i(b - 9, off));
      end
      bus.ld_valid = 1'b1;
      #1;
      chk("we_m1", 32'(bus.we_m1), (b < 9) ? 32'd1 : 32'd0);
      chk("we_m2", 32'(bus.we_m2), (b >= 9) ? 32'd1 : 32'd0);
      chk("wr_addr", 32'(bus.wr_addr), 32'(b % 9));
      @(negedge clk);
    end
    bus.ld_valid = 1'b0;
    #1;
    chk("run_entry", 32'(dut.state), 32'(ST_RUN));
  endtask

  // Entered in RUN cycle 0; returns in the cycle after done
  task automatic finish_run(input int off);
    int n;
    int loads;
    int rb;
    int db;
    rb    = res_cnt;
    db    = done_cnt;
    n     = 0;
    loads = 0;
    while (bus.done !== 1'b1 && n < 60) begin
      if (dut.state == ST_LOAD) loads++;
      if (n <= 3) begin
        chk("acc_ena_lat", 32'(bus.acc_ena), (n == 3) ? 32'd1 : 32'd0);
        chk("acc_clr_lat", 32'(bus.acc_clr), (n == 3) ? 32'd1 : 32'd0);
      end
      if (n == 5) begin
        chk("issue5_m1", 32'(bus.rd_addr_m1), 32'd2);
        chk("issue5_m2", 32'(bus.rd_addr_m2), 32'd7);
      end
      if (n == 26) chk("run_last", 32'(dut.state), 32'(ST_RUN));
      if (n == 27) begin
        chk("drain_entry", 32'(dut.state), 32'(ST_DRAIN));
        chk("hold_m1", 32'(bus.rd_addr_m1), 32'd8);
        chk("hold_m2", 32'(bus.rd_addr_m2), 32'd8);
      end
      @(negedge clk);
      n++;
    end
    chk("done_at", 32'(n), 32'd31);
    chk("no_restart", 32'(loads), 32'd0);
    @(negedge clk);
    chk("done_once", 32'(done_cnt - db), 32'd1);
    chk("res_count", 32'(res_cnt - rb), 32'd9);
    chk("hold_idle_m1", 32'(bus.rd_addr_m1), 32'd8);
    for (int e = 0; e < 9; e++) begin
      chk("res_idx", 32'(res_idx_log[rb + e]), 32'(e));
      chk("res_re", 32'(res_re_log[rb + e]), 32'(m2r(e, off)));
      chk("res_im", 32'(res_im_log[rb + e]), 32'(m2i(e, off)));
    end
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.ld_valid = 1'b0;
    ld_re        = '0;
    ld_im        = '0;

    #2 rst = 1'b0;
    #1;
    chk("rst_state", 32'(dut.state), 32'(ST_IDLE));
    chk("rst_outs", outs(), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("idle_busy", 32'(bus.busy), 32'd0);

    // Run A: continuous load, full multiply
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("load_state", 32'(dut.state), 32'(ST_LOAD));
    chk("ld_ready", 32'(bus.ld_ready), 32'd1);
    chk("busy_load", 32'(bus.busy), 32'd1);
    do_load(99, 0, 0);
    finish_run(0);
    chk("a_idle", 32'(dut.state), 32'(ST_IDLE));
    chk("a_busy", 32'(bus.busy), 32'd0);
    @(negedge clk);
    chk("a_stay_idle", 32'(dut.state), 32'(ST_IDLE));

    // Run B: load with a 5-cycle gap, reset in RUN cycle 10
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("b_load", 32'(dut.state), 32'(ST_LOAD));
    do_load(6, 5, 5);
    repeat (10) @(negedge clk);
    chk("pre_rst_m1", 32'(bus.rd_addr_m1), 32'd4);
    chk("pre_rst_m2", 32'(bus.rd_addr_m2), 32'd3);
    chk("pre_rst_ena", 32'(bus.acc_ena), 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_rst_outs", outs(), 32'd0);
    chk("mid_rst_state", 32'(dut.state), 32'(ST_IDLE));
    @(negedge clk);
    rst = 1'b1;

    // Run C: start held high for the whole run
    bus.start = 1'b1;
    @(negedge clk);
    chk("c_load", 32'(dut.state), 32'(ST_LOAD));
    do_load(99, 0, -2);
    finish_run(-2);
    chk("c_idle", 32'(dut.state), 32'(ST_IDLE));
    @(negedge clk);
    chk("c_restart", 32'(dut.state), 32'(ST_LOAD));
    chk("c_ld_ready", 32'(bus.ld_ready), 32'd1);
    bus.start = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
